// File: rtl/stream_demux2_slot.sv
// ---------------------------------------------------------------------------
// demux_slot -- two-entry FIFO used as the per-output buffer of stream_demux2.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous, active-high; empties the FIFO and clears storage
//   i_push       write i_push_data at the tail (ignored when full)
//   i_push_data  payload to store
//   i_pop        drop the head entry (ignored when empty)
//   o_head_data  oldest stored entry, taken directly from storage registers
//   o_full       two entries held
//   o_empty      no entries held
// ---------------------------------------------------------------------------
module demux_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] w_entry [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

  // Guards make the FIFO safe on its own even if a caller ignores full/empty.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Storage entries are cleared on reset so the head reads zero while empty
  // after reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      logic [DATA_WIDTH-1:0] r_entry;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_entry <= '0;
        end else if (w_push && (r_wr_ptr == IDX)) begin
          r_entry <= i_push_data;
        end
      end

      assign w_entry[gi] = r_entry;
    end
  endgenerate

  assign o_head_data = w_entry[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Push and pop in the same cycle leave occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux2.sv
// ---------------------------------------------------------------------------
// stream_demux2 -- routes a valid/ready stream to one of two outputs, each
// buffered by its own two-entry FIFO, and counts completed output transfers.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   in_data/in_sel/in_valid   upstream offer (in_sel: 0 -> out0, 1 -> out1)
//   in_ready                  offer accepted this cycle (selected slot not full)
//   outN_data/outN_valid      head of slot N, registered
//   outN_ready                downstream consumes outN
//   cntN                      completed transfers on outN, wrapping
// ---------------------------------------------------------------------------
module stream_demux2 #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1
);

  logic [1:0]            w_full;
  logic [1:0]            w_empty;
  logic [1:0]            w_out_ready;
  logic [DATA_WIDTH-1:0] w_head [2];
  logic [CNT_WIDTH-1:0]  w_cnt  [2];
  logic                  w_accept;

  assign w_out_ready = {out1_ready, out0_ready};

  // in_ready looks only at the selected slot's registered fill state, so a
  // stalled output never blocks traffic headed for the other one and there
  // is no combinational path from the downstream ready inputs.
  assign in_ready = in_sel ? ~w_full[1] : ~w_full[0];
  assign w_accept = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam logic IDX = 1'(gi);
      logic                 w_push;
      logic                 w_pop;
      logic [CNT_WIDTH-1:0] r_cnt;

      assign w_push = w_accept & (in_sel == IDX);
      // outN_ready is ignored while the slot is empty.
      assign w_pop  = ~w_empty[gi] & w_out_ready[gi];

      demux_slot #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_head_data (w_head[gi]),
        .o_full      (w_full[gi]),
        .o_empty     (w_empty[gi])
      );

      // Free-running modulo counter: wraps to zero, never saturates.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_pop) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign out0_valid = ~w_empty[0];
  assign out1_valid = ~w_empty[1];
  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign cnt0       = w_cnt[0];
  assign cnt1       = w_cnt[1];

endmodule

// File: tb/tb_stream_demux2.sv
// ---------------------------------------------------------------------------
// tb_stream_demux2 -- self-checking bench for stream_demux2 (CNT_WIDTH = 4 so
// counter wrap is reachable quickly).
// ---------------------------------------------------------------------------
module tb_stream_demux2;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out0_data;
  logic          out0_valid;
  logic          out0_ready = 1'b0;
  logic [DW-1:0] out1_data;
  logic          out1_valid;
  logic          out1_ready = 1'b0;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  always #5 clk = ~clk;

  stream_demux2 #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_cnt0 = 0;
  int          m_cnt1 = 0;

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " out0_valid"}, out0_valid, q0.size() > 0);
    chk({tag, " out1_valid"}, out1_valid, q1.size() > 0);
    if (q0.size() > 0) chk({tag, " out0_data"}, out0_data, q0[0]);
    if (q1.size() > 0) chk({tag, " out1_data"}, out1_data, q1[0]);
    chk({tag, " cnt0"}, 32'(cnt0), m_cnt0);
    chk({tag, " cnt1"}, 32'(cnt1), m_cnt1);
  endtask

  // One clock cycle: drive, check in_ready, advance the model, check outputs.
  task automatic model_step(input logic v, input logic sel, input logic [31:0] d,
                            input logic r0, input logic r1, output logic accepted);
    logic exp_rdy;
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = ((sel ? q1.size() : q0.size()) < 2);
    chk("m in_ready", in_ready, exp_rdy);
    if (r0 && q0.size() > 0) begin
      void'(q0.pop_front());
      m_cnt0 = (m_cnt0 + 1) % CNT_MOD;
    end
    if (r1 && q1.size() > 0) begin
      void'(q1.pop_front());
      m_cnt1 = (m_cnt1 + 1) % CNT_MOD;
    end
    accepted = v && exp_rdy;
    if (accepted) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    @(posedge clk);
    #1;
    check_outputs("m");
  endtask

  // Assert reset between edges, check its immediate effect, release it.
  task automatic do_reset(input int delay_ns);
    #(delay_ns);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    model_clear();
    chk("rst out0_valid", out0_valid, 1'b0);
    chk("rst out1_valid", out1_valid, 1'b0);
    chk("rst out0_data", out0_data, 32'h0);
    chk("rst out1_data", out1_data, 32'h0);
    chk("rst cnt0", 32'(cnt0), 32'h0);
    chk("rst cnt1", 32'(cnt1), 32'h0);
    chk("rst in_ready", in_ready, 1'b1);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst held out0_valid", out0_valid, 1'b0);
    chk("rst held cnt0", 32'(cnt0), 32'h0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
    int          e_c0;
    int          e_c1;
  } vec_t;

  function automatic vec_t mk(logic v, logic sel, logic [31:0] d, logic r0, logic r1,
                              logic e_rdy, logic e_v0, logic [31:0] e_d0,
                              logic e_v1, logic [31:0] e_d1, int e_c0, int e_c1);
    vec_t t;
    t.v = v; t.sel = sel; t.d = d; t.r0 = r0; t.r1 = r1;
    t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0;
    t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_c0 = e_c0; t.e_c1 = e_c1;
    return t;
  endfunction

  vec_t tbl[13];

  initial begin
    logic        acc;
    logic        held;
    logic [31:0] hold_d;
    logic        hold_sel;
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    int          lim0;
    int          lim1;

    //          v  sel d             r0 r1  rdy v0 d0            v1 d1     c0 c1
    // basic routing
    tbl[0]  = mk(1, 0, 32'hA5A5_0001, 1, 0,  1, 1, 32'hA5A5_0001, 0, 32'h0, 0, 0);
    tbl[1]  = mk(0, 0, 32'h0,         1, 0,  1, 0, 32'h0,         0, 32'h0, 1, 0);
    // backpressure on out0: third offer refused
    tbl[2]  = mk(1, 0, 32'h1,         0, 0,  1, 1, 32'h1,         0, 32'h0, 1, 0);
    tbl[3]  = mk(1, 0, 32'h2,         0, 0,  1, 1, 32'h1,         0, 32'h0, 1, 0);
    tbl[4]  = mk(1, 0, 32'h3,         0, 0,  0, 1, 32'h1,         0, 32'h0, 1, 0);
    // out0 full and stalled, out1 still accepts
    tbl[5]  = mk(1, 1, 32'h77,        0, 0,  1, 1, 32'h1,         1, 32'h77, 1, 0);
    // drain out0 in order, 0x3 accepted once space opens
    tbl[6]  = mk(1, 0, 32'h3,         1, 1,  0, 1, 32'h2,         0, 32'h0, 2, 1);
    tbl[7]  = mk(1, 0, 32'h3,         1, 0,  1, 1, 32'h3,         0, 32'h0, 3, 1);
    tbl[8]  = mk(0, 0, 32'h0,         1, 0,  1, 0, 32'h0,         0, 32'h0, 4, 1);
    // slot 1 streaming with simultaneous push/pop, no bubble
    tbl[9]  = mk(1, 1, 32'h0F,        0, 0,  1, 0, 32'h0,         1, 32'h0F, 4, 1);
    tbl[10] = mk(1, 1, 32'h10,        0, 1,  1, 0, 32'h0,         1, 32'h10, 4, 2);
    tbl[11] = mk(1, 1, 32'h11,        0, 1,  1, 0, 32'h0,         1, 32'h11, 4, 3);
    tbl[12] = mk(0, 1, 32'h0,         0, 1,  1, 0, 32'h0,         0, 32'h0,  4, 4);

    do_reset(0);

    for (int i = 0; i < 13; i++) begin
      in_valid   = tbl[i].v;
      in_sel     = tbl[i].sel;
      in_data    = tbl[i].d;
      out0_ready = tbl[i].r0;
      out1_ready = tbl[i].r1;
      #1;
      chk($sformatf("t%0d in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d out0_valid", i), out0_valid, tbl[i].e_v0);
      chk($sformatf("t%0d out1_valid", i), out1_valid, tbl[i].e_v1);
      if (tbl[i].e_v0) chk($sformatf("t%0d out0_data", i), out0_data, tbl[i].e_d0);
      if (tbl[i].e_v1) chk($sformatf("t%0d out1_data", i), out1_data, tbl[i].e_d1);
      chk($sformatf("t%0d cnt0", i), 32'(cnt0), tbl[i].e_c0);
      chk($sformatf("t%0d cnt1", i), 32'(cnt1), tbl[i].e_c1);
      $display("table row %0d applied", i);
    end

    // ---------------- counter wrap: 17 out1 transfers ----------------
    do_reset(2);
    for (int i = 0; i < 17; i++) begin
      model_step(1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b1, acc);
    end
    chk("wrap cnt1 after 16", 32'(cnt1), 32'h0);
    model_step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, acc);
    chk("wrap cnt1 after 17", 32'(cnt1), 32'h1);
    $display("counter wrap sequence done");

    // ---------------- randomized traffic ----------------
    held     = 1'b0;
    hold_d   = '0;
    hold_sel = 1'b0;
    for (int i = 0; i < 600; i++) begin
      // Vary downstream pressure over time to reach full/empty often.
      lim0 = (i / 75) % 4 * 3;
      lim1 = 9 - lim0;
      v    = ($urandom_range(0, 3) != 0);
      sel  = 1'($urandom_range(0, 1));
      d    = $urandom;
      r0   = ($urandom_range(0, 9) < lim0);
      r1   = ($urandom_range(0, 9) < lim1);
      if (held) begin
        // A refused offer keeps its data; the route may be re-chosen.
        v = 1'b1;
        d = hold_d;
        if ($urandom_range(0, 3) != 0) sel = hold_sel;
      end
      model_step(v, sel, d, r0, r1, acc);
      held     = v && !acc;
      hold_d   = d;
      hold_sel = sel;
    end
    $display("random traffic done");

    // ---------------- reset in mid-operation ----------------
    model_step(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, acc);
    model_step(1'b1, 1'b1, 32'hD1, 1'b0, 1'b0, acc);
    model_step(1'b1, 1'b0, 32'hD2, 1'b0, 1'b0, acc);
    model_step(1'b1, 1'b1, 32'hD3, 1'b0, 1'b0, acc);
    chk("pre-reset out0_valid", out0_valid, 1'b1);
    chk("pre-reset out1_valid", out1_valid, 1'b1);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      model_step(1'b0, 1'(i), 32'h0, 1'b1, 1'b1, acc);
    end
    $display("mid-operation reset done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_demux2.md
STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each per-output transfer counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_data  input  DATA_WIDTH  payload to route.
REQ-006 SHALL have port in_sel  input  1  route select: 0 routes to out0, 1 routes to out1.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data/in_sel.
REQ-008 SHALL have port in_ready  output  1  block accepts the offer this cycle.
REQ-009 SHALL have ports out0_data / out1_data  output  DATA_WIDTH  routed payload.
REQ-010 SHALL have ports out0_valid / out1_valid  output  1  payload present on that output.
REQ-011 SHALL have ports out0_ready / out1_ready  input  1  downstream consumes that output.
REQ-012 SHALL have ports cnt0 / cnt1  output  CNT_WIDTH  completed transfers on out0 / out1.

Function
REQ-013 SHALL accept an input transfer when in_valid and in_ready are both 1 on a rising edge.
REQ-014 SHALL give each output its own 2-entry FIFO buffer (slot), written only by transfers whose in_sel selects it.
REQ-015 SHALL drive in_ready = NOT full of the slot selected by in_sel. This is a combinational path from in_sel and registered slot state only, with no path from out0_ready or out1_ready.
REQ-016 SHALL drive outN_valid = NOT empty of slot N, and outN_data = head entry of slot N, both from registers.
REQ-017 SHALL complete an output transfer on slot N when outN_valid and outN_ready are both 1; the head is then popped.
REQ-018 SHALL have 1-cycle latency: data accepted at edge k appears on outN at edge k when slot N was empty, otherwise behind older entries in FIFO order.
REQ-019 SHALL, on simultaneous push and pop of the same slot, keep the occupancy unchanged and preserve order. When the slot is full, the push cannot occur because in_ready=0.
REQ-020 SHALL let slots operate independently: a full or stalled out0 SHALL NOT block in_sel=1 traffic, and the reverse also holds.
REQ-021 SHALL keep each slot's occupancy in {0,1,2}; full = 2 and empty = 0.
REQ-022 SHALL ignore in_data and in_sel when in_valid=0, and ignore outN_ready when outN_valid=0.
REQ-023 SHALL increment cntN by 1 on each completed out N transfer, wrapping from 2^CNT_WIDTH-1 to 0 with no saturation.
REQ-024 SHALL require upstream to hold in_data/in_sel stable while in_valid=1 and in_ready=0. Since in_ready depends on in_sel, changing in_sel while waiting is legal and re-evaluates in_ready.

Reset
REQ-025 SHALL, while rst=1, force both slots empty, outN_valid=0, outN_data=0 and cntN=0. This takes effect immediately and independently of clk.
REQ-026 SHALL discard all buffered entries on reset asserted mid-operation; no transfer SHALL complete during reset.
REQ-027 SHALL drive in_ready=1 while reset is held, since both slots are empty. Upstream SHALL NOT present in_valid until rst has been low for at least one clock edge.

Structure
REQ-028 SHALL place no typedefs in a shared package; DATA_WIDTH and CNT_WIDTH are module parameters only.
REQ-029 SHALL implement each buffer as one sub-module, demux_slot: a parameterised 2-entry FIFO with push/pop/full/empty, instantiated twice.
REQ-030 SHALL keep routing, in_ready generation and counters in stream_demux2 top level.

Verification
REQ-031 SHALL cover basic routing: in_data=0xA5A5_0001, in_sel=0, in_valid=1, out0_ready=1 -> out0_valid=1 with out0_data=0xA5A5_0001 one cycle later; out1_valid stays 0; cnt0=1.
REQ-032 SHALL cover backpressure: out0_ready=0 with three in_sel=0 offers 0x1,0x2,0x3 -> first two accepted, in_ready=0 on the third; then out0_ready=1 -> 0x1,0x2,0x3 drain in order.
REQ-033 SHALL cover independence: out0 full and stalled, offer in_sel=1 data 0x77 -> in_ready=1, out1_data=0x77 next cycle.
REQ-034 SHALL cover simultaneous push/pop: slot 1 holds one entry with out1_ready=1, push 0x10 -> occupancy stays 1, streaming continues every cycle with no bubble.
REQ-035 SHALL cover counter wrap: CNT_WIDTH=4, complete 17 out1 transfers -> cnt1 reads 1.
REQ-036 SHALL cover reset mid-operation: both slots full, assert rst asynchronously between edges -> outN_valid=0 and cntN=0 immediately; after release, previously buffered data never appears.
